// File: rtl/wshb_arbiter.sv
// Two-master, one-slave Wishbone arbiter with registered round-robin grants and
// a bounded-burst preemption so a master holding cyc forever cannot starve the other.
module wshb_arbiter #(
  parameter int MAX_BURST = 64,
  parameter int ADR_W     = 32
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             m0_cyc,
  input  logic             m0_stb,
  input  logic             m0_we,
  input  logic [ADR_W-1:0] m0_adr,
  input  logic [31:0]      m0_dat_ms,
  input  logic [3:0]       m0_sel,
  input  logic [2:0]       m0_cti,
  input  logic [1:0]       m0_bte,
  output logic [31:0]      m0_dat_sm,
  output logic             m0_ack,

  input  logic             m1_cyc,
  input  logic             m1_stb,
  input  logic             m1_we,
  input  logic [ADR_W-1:0] m1_adr,
  input  logic [31:0]      m1_dat_ms,
  input  logic [3:0]       m1_sel,
  input  logic [2:0]       m1_cti,
  input  logic [1:0]       m1_bte,
  output logic [31:0]      m1_dat_sm,
  output logic             m1_ack,

  output logic             s_cyc,
  output logic             s_stb,
  output logic             s_we,
  output logic [ADR_W-1:0] s_adr,
  output logic [31:0]      s_dat_ms,
  output logic [3:0]       s_sel,
  output logic [2:0]       s_cti,
  output logic [1:0]       s_bte,
  input  logic [31:0]      s_dat_sm,
  input  logic             s_ack,

  output logic [1:0]       grant
);

  localparam int ACK_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, GAP} state_t;

  state_t           r_state;
  logic             r_last;
  logic [ACK_W-1:0] r_acks;
  logic [1:0]       r_grant;

  logic w_sel0, w_sel1;
  logic w_own, w_own_cyc, w_oth_cyc;
  logic w_cyc_l, w_cyc_nl;
  logic w_go, w_pick;

  function automatic logic at_limit(input logic [ACK_W-1:0] a);
    return (32'(a) + 32'd1) >= 32'(MAX_BURST);
  endfunction

  function automatic logic [ACK_W-1:0] sat_inc(input logic [ACK_W-1:0] a);
    if (32'(a) >= 32'(MAX_BURST)) return a;
    return a + ACK_W'(1);
  endfunction

  // Reset gates the path in the same cycle so an in-flight ack is dropped.
  assign w_sel0 = (r_state == GNT0) && !rst;
  assign w_sel1 = (r_state == GNT1) && !rst;

  assign w_own     = (r_state == GNT1);
  assign w_own_cyc = w_own ? m1_cyc : m0_cyc;
  assign w_oth_cyc = w_own ? m0_cyc : m1_cyc;
  assign w_cyc_l   = r_last ? m1_cyc : m0_cyc;
  assign w_cyc_nl  = r_last ? m0_cyc : m1_cyc;

  // Which master (if any) takes ownership at the next edge.
  always_comb begin
    w_go   = 1'b0;
    w_pick = 1'b0;
    case (r_state)
      IDLE: begin
        w_go   = m0_cyc || m1_cyc;
        w_pick = (m0_cyc && m1_cyc) ? ~r_last : m1_cyc;
      end
      GAP: begin
        w_go   = w_cyc_nl || w_cyc_l;
        w_pick = w_cyc_nl ? ~r_last : r_last;
      end
      GNT0, GNT1: begin
        w_go   = !w_own_cyc && w_oth_cyc;
        w_pick = ~w_own;
      end
      default: begin
        w_go   = 1'b0;
        w_pick = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_acks  <= '0;
      r_grant <= 2'b00;
    end else if (w_go) begin
      r_state <= w_pick ? GNT1 : GNT0;
      r_last  <= w_pick;
      r_acks  <= '0;
      r_grant <= w_pick ? 2'b10 : 2'b01;
    end else begin
      case (r_state)
        GNT0, GNT1: begin
          if (!w_own_cyc) begin
            r_state <= IDLE;
            r_grant <= 2'b00;
          end else if (w_oth_cyc && s_ack && at_limit(r_acks)) begin
            // Preempt on the transfer boundary; this final ack still reaches the owner.
            r_state <= GAP;
            r_grant <= 2'b00;
          end else if (s_ack) begin
            r_acks <= sat_inc(r_acks);
          end
        end
        GAP: begin
          r_state <= IDLE;
          r_grant <= 2'b00;
        end
        default: begin
          r_state <= IDLE;
          r_grant <= 2'b00;
        end
      endcase
    end
  end

  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    s_cti    = '0;
    s_bte    = '0;
    if (w_sel0) begin
      s_cyc    = m0_cyc;
      s_stb    = m0_stb;
      s_we     = m0_we;
      s_adr    = m0_adr;
      s_dat_ms = m0_dat_ms;
      s_sel    = m0_sel;
      s_cti    = m0_cti;
      s_bte    = m0_bte;
    end else if (w_sel1) begin
      s_cyc    = m1_cyc;
      s_stb    = m1_stb;
      s_we     = m1_we;
      s_adr    = m1_adr;
      s_dat_ms = m1_dat_ms;
      s_sel    = m1_sel;
      s_cti    = m1_cti;
      s_bte    = m1_bte;
    end
  end

  assign m0_ack    = w_sel0 && s_ack;
  assign m1_ack    = w_sel1 && s_ack;
  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;
  assign grant     = r_grant;

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed self-checking bench for wshb_arbiter with MAX_BURST=4.
module tb_wshb_arbiter;

  localparam int ADR_W = 32;

  logic             clk;
  logic             rst;
  logic             m0_cyc, m0_stb, m0_we;
  logic [ADR_W-1:0] m0_adr;
  logic [31:0]      m0_dat_ms, m0_dat_sm;
  logic [3:0]       m0_sel;
  logic [2:0]       m0_cti;
  logic [1:0]       m0_bte;
  logic             m0_ack;
  logic             m1_cyc, m1_stb, m1_we;
  logic [ADR_W-1:0] m1_adr;
  logic [31:0]      m1_dat_ms, m1_dat_sm;
  logic [3:0]       m1_sel;
  logic [2:0]       m1_cti;
  logic [1:0]       m1_bte;
  logic             m1_ack;
  logic             s_cyc, s_stb, s_we;
  logic [ADR_W-1:0] s_adr;
  logic [31:0]      s_dat_ms, s_dat_sm;
  logic [3:0]       s_sel;
  logic [2:0]       s_cti;
  logic [1:0]       s_bte;
  logic             s_ack;
  logic [1:0]       grant;

  int n_assert;
  int n_fail;
  int n_ack;
  int n_bad;
  int guard;

  wshb_arbiter #(.MAX_BURST(4), .ADR_W(ADR_W)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_bte(m0_bte),
    .m0_dat_sm(m0_dat_sm), .m0_ack(m0_ack),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_cti(m1_cti), .m1_bte(m1_bte),
    .m1_dat_sm(m1_dat_sm), .m1_ack(m1_ack),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
    .s_dat_sm(s_dat_sm), .s_ack(s_ack),
    .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    rst = 1'b1; s_ack = 1'b0; s_dat_sm = 32'h0;
    m0_cyc = 0; m0_stb = 0; m0_we = 1'b1; m0_adr = 32'h0000_1000;
    m0_dat_ms = 32'h1111_AAAA; m0_sel = 4'hF; m0_cti = 3'b010; m0_bte = 2'b01;
    m1_cyc = 0; m1_stb = 0; m1_we = 1'b0; m1_adr = 32'h0000_2000;
    m1_dat_ms = 32'h2222_BBBB; m1_sel = 4'h3; m1_cti = 3'b111; m1_bte = 2'b10;

    // Reset state with a stray slave ack
    cycle(); s_ack = 1'b1; settle();
    check("rst_grant", grant, 2'b00);
    check("rst_s_cyc", s_cyc, 0);
    check("rst_m0_ack", m0_ack, 0);
    check("rst_s_adr", s_adr, 0);

    // Single master 0 request
    cycle(); rst = 1'b0; s_ack = 1'b0; m0_cyc = 1; m0_stb = 1; settle();
    check("idle_s_cyc", s_cyc, 0);
    cycle(); settle();
    check("g0_grant", grant, 2'b01);
    check("g0_s_cyc", s_cyc, 1);
    check("g0_s_stb", s_stb, 1);
    check("g0_s_we", s_we, 1);
    check("g0_s_adr", s_adr, 32'h0000_1000);
    check("g0_s_dat_ms", s_dat_ms, 32'h1111_AAAA);
    check("g0_s_sel", s_sel, 4'hF);
    check("g0_s_cti", s_cti, 3'b010);
    check("g0_s_bte", s_bte, 2'b01);
    cycle(); s_ack = 1'b1; s_dat_sm = 32'hCAFE_F00D; settle();
    check("g0_m0_ack", m0_ack, 1);
    check("g0_m1_ack", m1_ack, 0);
    check("g0_m0_dat", m0_dat_sm, 32'hCAFE_F00D);
    check("g0_m1_dat", m1_dat_sm, 32'hCAFE_F00D);
    cycle(); s_ack = 1'b0; settle();
    check("g0_m0_ack_low", m0_ack, 0);
    cycle(); m0_cyc = 0; m0_stb = 0; settle();
    check("g0_release_s_cyc", s_cyc, 0);
    cycle(); settle();
    check("g0_back_idle", grant, 2'b00);

    // Tie after reset goes to master 0, voluntary release hands over with no gap
    cycle(); rst = 1'b1; settle();
    cycle(); rst = 1'b0; m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; settle();
    cycle(); settle();
    check("tie_grant", grant, 2'b01);
    check("tie_s_adr", s_adr, 32'h0000_1000);
    cycle(); m0_cyc = 0; m0_stb = 0; settle();
    check("tie_drop_grant", grant, 2'b01);
    cycle(); settle();
    check("handover_grant", grant, 2'b10);
    check("handover_s_cyc", s_cyc, 1);
    check("handover_s_adr", s_adr, 32'h0000_2000);
    check("handover_s_we", s_we, 0);
    check("handover_s_sel", s_sel, 4'h3);
    cycle(); m1_cyc = 0; m1_stb = 0; settle();
    cycle(); settle();
    check("handover_idle", grant, 2'b00);

    // Preemption after 4 acks while master 1 requests (last=1, so master 0 wins)
    cycle(); m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1'b1; settle();
    check("pre_idle_m0_ack", m0_ack, 0);
    cycle(); settle();
    check("pre_grant", grant, 2'b01);
    n_ack = 0; guard = 0;
    while (grant == 2'b01 && guard < 20) begin
      if (m0_ack) n_ack++;
      guard++;
      cycle(); settle();
    end
    check("pre_ack_count", n_ack, 4);
    check("gap_grant", grant, 2'b00);
    check("gap_s_cyc", s_cyc, 0);
    check("gap_s_stb", s_stb, 0);
    check("gap_m0_ack", m0_ack, 0);
    check("gap_m1_ack", m1_ack, 0);
    cycle(); settle();
    check("post_gap_grant", grant, 2'b10);
    check("post_gap_s_adr", s_adr, 32'h0000_2000);
    check("post_gap_m1_ack", m1_ack, 1);
    check("post_gap_m0_ack", m0_ack, 0);
    cycle(); m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack = 1'b0; settle();
    cycle(); settle();
    check("pre_done_idle", grant, 2'b00);

    // Master 0 alone keeps the bus for 1000 acks, then immediate preemption
    cycle(); m0_cyc = 1; m0_stb = 1; s_ack = 1'b1; settle();
    cycle(); settle();
    n_ack = 0; n_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (m0_ack) n_ack++;
      if (grant != 2'b01 || !s_cyc) n_bad++;
      cycle(); settle();
    end
    check("solo_ack_count", n_ack, 1000);
    check("solo_no_gap", n_bad, 0);
    check("solo_acks_sat", dut.r_acks, 4);
    m1_cyc = 1; m1_stb = 1; #1;
    check("solo_last_ack", m0_ack, 1);
    cycle(); settle();
    check("solo_gap_grant", grant, 2'b00);
    check("solo_gap_s_cyc", s_cyc, 0);
    cycle(); settle();
    check("solo_m1_grant", grant, 2'b10);
    check("solo_m1_ack", m1_ack, 1);

    // Reset mid-burst of master 1 drops the in-flight ack
    cycle(); rst = 1'b1; settle();
    check("rst_mid_m1_ack", m1_ack, 0);
    check("rst_mid_s_cyc", s_cyc, 0);
    cycle(); settle();
    check("rst_after_grant", grant, 2'b00);
    check("rst_after_s_cyc", s_cyc, 0);
    check("rst_after_s_adr", s_adr, 0);
    check("rst_after_m1_ack", m1_ack, 0);
    check("rst_after_m0_ack", m0_ack, 0);
    cycle(); rst = 1'b0; s_ack = 1'b0; settle();
    cycle(); settle();
    check("rst_tie_grant", grant, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
